// File: rtl/rvm_adder_seq_pkg.sv
// Op codes and FSM state encodings shared by the sequential add/subtract unit
// and anything that drives it.
`default_nettype none

package rvm_adder_seq_pkg;

  localparam logic [2:0] RVM_ARITH_NOP = 3'd0;
  localparam logic [2:0] RVM_ARITH_ADD = 3'd1;
  localparam logic [2:0] RVM_ARITH_SUB = 3'd2;

  typedef enum logic [1:0] {
    RVM_ADDSEQ_IDLE = 2'd0,
    RVM_ADDSEQ_BUSY = 2'd1,
    RVM_ADDSEQ_DONE = 2'd2
  } addseq_state_e;

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == RVM_ARITH_ADD) || (op == RVM_ARITH_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvm_adder_slice.sv
// Combinational CHUNK-bit adder slice: sum, carry-out and the carry into the
// top bit (needed for signed overflow of the full-width operation).
`default_nettype none

module rvm_adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [CHUNK:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = w_total[CHUNK-1:0];
  assign cout    = w_total[CHUNK];
  // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
  assign c_top   = a[CHUNK-1] ^ b[CHUNK-1] ^ w_total[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/rvm_adder_seq.sv
// Multi-cycle add/subtract unit, CHUNK bits per cycle LSB first, with eq/lt/ltu
// compare flags. Define RVM_ADDER_OVERFLOW_EN to expose the `overflow` port.
`default_nettype none

module rvm_adder_seq
  import rvm_adder_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN:0]   result,
  output logic            eq,
  output logic            lt,
  output logic            ltu
`ifdef RVM_ADDER_OVERFLOW_EN
  ,
  output logic            overflow
`endif
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (XLEN % CHUNK != 0) begin : g_chunk_check
    $error("rvm_adder_seq: XLEN must be a multiple of CHUNK");
  end

  addseq_state_e     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   lhs_q, lhs_d;
  logic [XLEN-1:0]   rhs_q, rhs_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     result_q, result_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic              ltu_q, ltu_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic                  w_is_sub;
  logic                  w_last;
  logic [CHUNK-1:0]      w_b;
  logic [CHUNK-1:0]      w_sum;
  logic                  w_cout;
  logic                  w_c_top;
  logic [XLEN+CHUNK-1:0] w_shift;

  assign w_is_sub = (op_q == RVM_ARITH_SUB);
  assign w_last   = (cnt_q == CNT_W'(NCHUNK - 1));
  assign w_b      = w_is_sub ? ~rhs_q[CHUNK-1:0] : rhs_q[CHUNK-1:0];
  // Operands shift right each cycle; finished chunks enter the result from the top.
  assign w_shift  = {w_sum, result_q[XLEN-1:0]} >> CHUNK;

  rvm_adder_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (lhs_q[CHUNK-1:0]),
    .b     (w_b),
    .cin   (carry_q),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_top (w_c_top)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lhs_d       = lhs_q;
    rhs_d       = rhs_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    ltu_d       = ltu_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      RVM_ADDSEQ_IDLE: begin
        if (in_valid && is_arith_op(op)) begin
          state_d  = RVM_ADDSEQ_BUSY;
          op_d     = op;
          lhs_d    = lhs;
          rhs_d    = rhs;
          carry_d  = (op == RVM_ARITH_SUB);
          cnt_d    = '0;
          result_d = '0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          ltu_d    = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RVM_ADDSEQ_BUSY: begin
        lhs_d                = lhs_q >> CHUNK;
        rhs_d                = rhs_q >> CHUNK;
        result_d[XLEN-1:0]   = w_shift[XLEN-1:0];
        carry_d              = w_cout;
        cnt_d                = cnt_q + CNT_W'(1);
        if (w_last) begin
          state_d        = RVM_ADDSEQ_DONE;
          result_d[XLEN] = w_is_sub ? ~w_cout : w_cout;
          ovf_d          = w_cout ^ w_c_top;
        end
      end
      RVM_ADDSEQ_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          eq_d        = w_is_sub && (result_q[XLEN-1:0] == '0);
          ltu_d       = w_is_sub && result_q[XLEN];
          lt_d        = w_is_sub && (result_q[XLEN-1] ^ ovf_q);
        end else if (out_ready) begin
          state_d     = RVM_ADDSEQ_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = RVM_ADDSEQ_IDLE;
    endcase

    if (flush) begin
      state_d     = RVM_ADDSEQ_IDLE;
      out_valid_d = 1'b0;
      carry_d     = 1'b0;
      cnt_d       = '0;
      result_d    = '0;
      eq_d        = 1'b0;
      lt_d        = 1'b0;
      ltu_d       = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RVM_ADDSEQ_IDLE;
      op_q        <= RVM_ARITH_NOP;
      lhs_q       <= '0;
      rhs_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lhs_q       <= lhs_d;
      rhs_q       <= rhs_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      ltu_q       <= ltu_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == RVM_ADDSEQ_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
`ifdef RVM_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvm_adder_seq.sv
// Bench for rvm_adder_seq: three instances (CHUNK 8, 32, 1) share one stimulus
// stream and are checked against an arithmetic reference model.
`default_nettype none

module tb_rvm_adder_seq;
  import rvm_adder_seq_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [31:0] lhs;
  logic [31:0] rhs;

  logic [2:0]       in_rdy;
  logic [2:0]       o_val;
  logic [2:0]       eq_o;
  logic [2:0]       lt_o;
  logic [2:0]       ltu_o;
  logic [2:0][32:0] res_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rvm_adder_seq #(.XLEN(32), .CHUNK(8)) u_c8 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_rdy[0]), .op(op), .lhs(lhs), .rhs(rhs),
    .out_valid(o_val[0]), .out_ready(out_ready), .result(res_o[0]),
    .eq(eq_o[0]), .lt(lt_o[0]), .ltu(ltu_o[0])
  );

  rvm_adder_seq #(.XLEN(32), .CHUNK(32)) u_c32 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_rdy[1]), .op(op), .lhs(lhs), .rhs(rhs),
    .out_valid(o_val[1]), .out_ready(out_ready), .result(res_o[1]),
    .eq(eq_o[1]), .lt(lt_o[1]), .ltu(ltu_o[1])
  );

  rvm_adder_seq #(.XLEN(32), .CHUNK(1)) u_c1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_rdy[2]), .op(op), .lhs(lhs), .rhs(rhs),
    .out_valid(o_val[2]), .out_ready(out_ready), .result(res_o[2]),
    .eq(eq_o[2]), .lt(lt_o[2]), .ltu(ltu_o[2])
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    case (i)
      0:       return 5;
      1:       return 2;
      default: return 33;
    endcase
  endfunction

  // Reference: zero-extended 33-bit add/sub plus direct comparisons.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [32:0] r, output logic [2:0] f);
    if (o == RVM_ARITH_SUB) begin
      r = {1'b0, a} - {1'b0, b};
      f = {a == b, $signed(a) < $signed(b), a < b};
    end else begin
      r = {1'b0, a} + {1'b0, b};
      f = 3'b000;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e_res;
    logic [2:0]  e_flg;
    logic        fire;
    logic [2:0]  seen;
    int          c;
    fire = is_arith_op(o);
    model(o, a, b, e_res, e_flg);
    check_val("in_ready_pre", {61'd0, in_rdy}, 64'd7);
    in_valid = 1'b1; op = o; lhs = a; rhs = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 3'b000;
    c = 0;
    while (c < 40 && !(fire && seen == 3'b111)) begin
      @(posedge clk); #1;
      c++;
      for (int i = 0; i < 3; i++) begin
        if (o_val[i] && !seen[i]) begin
          seen[i] = 1'b1;
          if (fire) begin
            check_val($sformatf("latency_i%0d", i), 64'(c), 64'(lat_of(i)));
            check_val($sformatf("result_i%0d", i), {31'd0, res_o[i]}, {31'd0, e_res});
            check_val($sformatf("flags_i%0d", i), {61'd0, eq_o[i], lt_o[i], ltu_o[i]}, {61'd0, e_flg});
          end
        end
      end
    end
    check_val(fire ? "valid_seen" : "nop_no_valid", {61'd0, seen}, fire ? 64'd7 : 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic abort_test(input logic use_reset);
    logic [2:0] seen_any;
    check_val("abort_ready_pre", {61'd0, in_rdy}, 64'd7);
    in_valid = 1'b1; op = RVM_ARITH_SUB; lhs = 32'd5; rhs = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    if (use_reset) begin
      resetn = 1'b0;
      #1;
      check_val("rst_async_ready", {61'd0, in_rdy}, 64'd7);
      check_val("rst_async_result", {31'd0, res_o[2]}, 64'd0);
    end else begin
      flush = 1'b1;
    end
    @(posedge clk); #1;
    flush  = 1'b0;
    resetn = 1'b1;
    check_val(use_reset ? "rst_ready" : "flush_ready", {61'd0, in_rdy}, 64'd7);
    check_val(use_reset ? "rst_valid" : "flush_valid", {61'd0, o_val}, 64'd0);
    seen_any = 3'b000;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      seen_any = seen_any | o_val;
    end
    check_val(use_reset ? "rst_no_valid" : "flush_no_valid", {61'd0, seen_any}, 64'd0);
  endtask

  initial begin
    logic [32:0] e_res;
    logic [2:0]  e_flg;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o;
    int          c;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = RVM_ARITH_NOP; lhs = '0; rhs = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_in_ready", {61'd0, in_rdy}, 64'd7);
    check_val("reset_out_valid", {61'd0, o_val}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("reset_result_i%0d", i), {31'd0, res_o[i]}, 64'd0);
      check_val($sformatf("reset_flags_i%0d", i), {61'd0, eq_o[i], lt_o[i], ltu_o[i]}, 64'd0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op(RVM_ARITH_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(RVM_ARITH_SUB, 32'd5, 32'd7);
    run_op(RVM_ARITH_SUB, 32'd9, 32'd9);
    run_op(RVM_ARITH_SUB, 32'h8000_0000, 32'd1);
    run_op(RVM_ARITH_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_op(RVM_ARITH_NOP, 32'd1, 32'd2);
    run_op(3'd5, 32'd3, 32'd4);

    // Backpressure: result must hold while out_ready is low; a NOP is ignored.
    out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    model(RVM_ARITH_ADD, a, b, e_res, e_flg);
    in_valid = 1'b1; op = RVM_ARITH_ADD; lhs = a; rhs = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (c < 40 && o_val != 3'b111) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("hold_all_valid", {61'd0, o_val}, 64'd7);
    in_valid = 1'b1; op = RVM_ARITH_NOP;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_val("hold_in_ready", {61'd0, in_rdy}, 64'd0);
      check_val("hold_valid", {61'd0, o_val}, 64'd7);
      for (int i = 0; i < 3; i++)
        check_val($sformatf("hold_result_i%0d", i), {31'd0, res_o[i]}, {31'd0, e_res});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("release_valid", {61'd0, o_val}, 64'd0);
    check_val("release_ready", {61'd0, in_rdy}, 64'd7);

    abort_test(1'b0);
    abort_test(1'b1);

    // Randomized operations, with operand corners mixed in.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = 32'h7FFF_FFFF;
        2:       b = 32'd0;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       o = 3'($urandom_range(3, 7));
        1:       o = RVM_ARITH_NOP;
        2, 3, 4: o = RVM_ARITH_ADD;
        default: o = RVM_ARITH_SUB;
      endcase
      run_op(o, a, b);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
